// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
// State encoding, protocol bytes and default inter-byte timeout.
package boot_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    RESPOND,
    RUN
  } boot_state_e;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  localparam int CLOCK_FREQ_OVER_BAUD_RATE = 72;
  localparam int BITS_PER_BYTE = 10;
  localparam int TIMEOUT_BYTES = 16;
  localparam int DEF_TIMEOUT_CYCLES =
    TIMEOUT_BYTES * BITS_PER_BYTE * CLOCK_FREQ_OVER_BAUD_RATE;

endpackage

// File: rtl/boot_word_packer.sv
// Packs little-endian payload bytes into 32-bit words.
// BOOT_CHECKSUM_EN adds a running XOR of all payload bytes.
module boot_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic [7:0]  csum
`endif
);

  logic [23:0] asm_q, asm_d;
  logic [1:0]  idx_q, idx_d;

  // shift bytes in from the top so byte 0 ends up lowest
  always_comb begin
    asm_d = asm_q;
    idx_d = idx_q;
    if (clr) begin
      asm_d = '0;
      idx_d = '0;
    end else if (shift_en) begin
      asm_d = {byte_in, asm_q[23:8]};
      idx_d = idx_q + 2'd1;
    end
  end

  // assembly registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
      idx_q <= '0;
    end else begin
      asm_q <= asm_d;
      idx_q <= idx_d;
    end
  end

  // the 4th byte completes the word combinationally
  always_comb begin
    word      = {byte_in, asm_q};
    word_done = shift_en && !clr && (idx_q == 2'd3);
  end

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  // running XOR over payload bytes only
  always_comb begin
    xor_d = xor_q;
    if (clr)           xor_d = '0;
    else if (shift_en) xor_d = xor_q ^ byte_in;
  end

  // checksum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xor_q <= '0;
    else        xor_q <= xor_d;
  end

  assign csum = xor_q;
`endif

endmodule

// File: rtl/uart_boot_ctrl.sv
// UART boot sequencer: frame parse, imem load, ACK/NAK, core release.
// Optional BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_boot_ctrl
  import boot_pkg::*;
#(
  parameter int          ADDR_W         = 10,
  parameter logic [7:0]  SYNC_BYTE      = SYNC,
  parameter logic [7:0]  ACK_BYTE       = ACK,
  parameter logic [7:0]  NAK_BYTE       = NAK,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_pin,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_n,
  output logic              boot_busy,
  output logic              boot_error
);

  localparam int MAX_WORDS = 2 ** ADDR_W;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  boot_state_e       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       len_in;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [1:0]        sync_cnt_q, sync_cnt_d;
  logic              resp_ack_q, resp_ack_d;
  logic              boot_error_q, boot_error_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              timed;
  logic              last_word;
  logic [31:0]       word;
  logic              word_done;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign len_in    = {rx_data, len_lo_q};
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);
  assign timed     = state_q inside {LEN_LO, LEN_HI, DATA, CHECK};

  boot_word_packer u_packer (
    .clk       (clk),
    .rst_n     (reset_pin),
    .clr       (state_q == LEN_LO),
    .shift_en  (state_q == DATA && rx_valid),
    .byte_in   (rx_data),
    .word      (word),
    .word_done (word_done)
`ifdef BOOT_CHECKSUM_EN
    ,
    .csum      (csum)
`endif
  );

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_pin) begin
    if (!reset_pin) begin
      state_q      <= WAIT_SYNC;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      to_cnt_q     <= '0;
      sync_cnt_q   <= '0;
      resp_ack_q   <= 1'b0;
      boot_error_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      to_cnt_q     <= to_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      resp_ack_q   <= resp_ack_d;
      boot_error_q <= boot_error_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // next state, frame bookkeeping and timeout
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    to_cnt_d     = '0;
    sync_cnt_d   = sync_cnt_q;
    resp_ack_d   = resp_ack_q;
    boot_error_d = boot_error_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if (timed) to_cnt_d = rx_valid ? '0 : to_cnt_q + 1'b1;
    unique case (state_q)
      WAIT_SYNC: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          len_d      = len_in;
          word_idx_d = '0;
          if (len_in == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d    = RESPOND;
            resp_ack_d = 1'b1;
`endif
          end else if (32'(len_in) > MAX_WORDS) begin
            state_d    = RESPOND;
            resp_ack_d = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_done) begin
          we_d    = 1'b1;
          addr_d  = word_idx_q;
          wdata_d = word;
        end
        if (we_q) begin
          word_idx_d = word_idx_q + 1'b1;
          if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d    = RESPOND;
            resp_ack_d = 1'b1;
`endif
          end
        end
      end
      CHECK: begin
`ifdef BOOT_CHECKSUM_EN
        if (rx_valid) begin
          state_d    = RESPOND;
          resp_ack_d = (rx_data == csum);
        end
`endif
      end
      RESPOND: begin
        if (tx_ready) begin
          boot_error_d = !resp_ack_q;
          state_d      = resp_ack_q ? RUN : WAIT_SYNC;
        end
      end
      RUN: begin
        if (rx_valid) begin
          if (rx_data != SYNC_BYTE) begin
            sync_cnt_d = '0;
          end else if (sync_cnt_q == 2'd2) begin
            sync_cnt_d = '0;
            state_d    = LEN_LO;
          end else begin
            sync_cnt_d = sync_cnt_q + 2'd1;
          end
        end
      end
    endcase
    if (timed && !rx_valid && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d    = RESPOND;
      resp_ack_d = 1'b0;
    end
  end

  // outputs decoded from registered state
  always_comb begin
    tx_valid    = (state_q == RESPOND);
    tx_data     = 8'h00;
    if (tx_valid) tx_data = resp_ack_q ? ACK_BYTE : NAK_BYTE;
    cpu_reset_n = (state_q == RUN);
    boot_busy   = state_q inside {LEN_LO, LEN_HI, DATA, CHECK, RESPOND};
    boot_error  = boot_error_q;
    imem_we     = we_q;
    imem_addr   = addr_q;
    imem_wdata  = wdata_q;
  end

endmodule
